// File: rtl/core_pkg.sv
// Shared core types and constants: address/instruction types, reset PC,
// NOP encoding, PC step and the IF/ID pipeline payload.
package core_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned CNT_W   = 16;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    localparam addr_t       RESET_PC_DEFAULT  = 16'h0000;
    localparam instr_t      NOP_INSTR_DEFAULT = 16'h0000;
    localparam int unsigned PC_STEP           = 2;

    // IF/ID pipeline register contents handed to decode
    typedef struct packed {
        logic   valid;
        instr_t instr;
        addr_t  pc;
        addr_t  pc_plus2;
    } ifid_t;

    // Instructions are halfword aligned; bit 0 is dropped silently
    function automatic addr_t align_pc(input addr_t a);
        return {a[ADDR_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, IF/ID outputs, stall/redirect controls
// and performance counters. master = fetch unit, slave = its environment.
interface fetch_unit_if;
    import core_pkg::*;

    logic   stall;
    logic   redirect_valid;
    addr_t  redirect_pc;
    addr_t  imem_pc;
    instr_t imem_instr;
    logic   ifid_valid;
    instr_t ifid_instr;
    addr_t  ifid_pc;
    addr_t  ifid_pc_plus2;
    cnt_t   fetch_count;
    cnt_t   bubble_count;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_instr,
        output imem_pc, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus2,
               fetch_count, bubble_count
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_instr,
        input  imem_pc, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus2,
               fetch_count, bubble_count
    );

endinterface

// File: rtl/fetch_unit_sat_counter.sv
// 16-bit saturating event counter with synchronous clear (clear wins over inc).
module sat_counter
    import core_pkg::*;
(
    input  logic clk,
    input  logic clear,
    input  logic inc,
    output cnt_t count
);

    localparam cnt_t CNT_MAX = '1;

    // Count up on inc, stick at all-ones
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection (reset > redirect
// > stall > advance) and IF/ID register. Optional performance counters are
// built only when FETCH_PERF_CNT_EN is defined; otherwise they read zero.
module fetch_unit
    import core_pkg::*;
#(
    parameter addr_t  RESET_PC  = RESET_PC_DEFAULT,
    parameter instr_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    addr_t pc_q;
    ifid_t ifid_q;
    addr_t pc_plus2_c;

    assign pc_plus2_c = pc_q + ADDR_W'(PC_STEP);

    // PC and IF/ID register update in priority order
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q            <= RESET_PC;
            ifid_q.valid    <= 1'b0;
            ifid_q.instr    <= NOP_INSTR;
            ifid_q.pc       <= '0;
            ifid_q.pc_plus2 <= '0;
        end else if (bus.redirect_valid) begin
            // Flush the slot; keep the old pc fields, they are don't-care
            pc_q         <= align_pc(bus.redirect_pc);
            ifid_q.valid <= 1'b0;
            ifid_q.instr <= NOP_INSTR;
        end else if (!bus.stall) begin
            pc_q            <= pc_plus2_c;
            ifid_q.valid    <= 1'b1;
            ifid_q.instr    <= bus.imem_instr;
            ifid_q.pc       <= pc_q;
            ifid_q.pc_plus2 <= pc_plus2_c;
        end
    end

    assign bus.imem_pc       = pc_q;
    assign bus.ifid_valid    = ifid_q.valid;
    assign bus.ifid_instr    = ifid_q.instr;
    assign bus.ifid_pc       = ifid_q.pc;
    assign bus.ifid_pc_plus2 = ifid_q.pc_plus2;

`ifdef FETCH_PERF_CNT_EN
    logic advance_c;
    logic bubble_c;
    cnt_t fetch_cnt;
    cnt_t bubble_cnt;

    assign advance_c = !bus.redirect_valid && !bus.stall;
    assign bubble_c  = !ifid_q.valid;

    sat_counter u_fetch_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (advance_c),
        .count (fetch_cnt)
    );

    sat_counter u_bubble_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (bubble_c),
        .count (bubble_cnt)
    );

    assign bus.fetch_count  = fetch_cnt;
    assign bus.bubble_count = bubble_cnt;
`else
    assign bus.fetch_count  = '0;
    assign bus.bubble_count = '0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the 16-bit core. It owns the program counter, drives the combinational instruction ROM address, and captures the returned instruction into the IF/ID pipeline register for the decoder. It supports pipeline stall and branch/jump redirect with flush. It sits between the ROM (downstream of the PC) and the decode stage (upstream of decode).

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `NOP_INSTR`, 16'h0000, instruction word inserted on flush/reset (all-zero is a NOP in this ISA).
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `stall` input 1: decode/hazard stall; hold PC and IF/ID contents.
- `redirect_valid` input 1: taken branch/jump from execute; overrides stall.
- `redirect_pc` input 16: byte address of the redirect target.
- `imem_pc` output 16: current PC to the ROM; equals the PC register.
- `imem_instr` input 16: ROM data for `imem_pc`; combinational, same cycle.
- `ifid_valid` output 1: IF/ID holds a real instruction.
- `ifid_instr` output 16: fetched instruction.
- `ifid_pc` output 16: address of `ifid_instr`.
- `ifid_pc_plus2` output 16: `ifid_pc + 2`, used for branch-offset and link calculations.
- `fetch_count` output 16: number of instructions fetched (performance counter; see Configuration).
- `bubble_count` output 16: number of cycles with `ifid_valid` low after reset (performance counter; see Configuration).

## Operation
- The PC register drives `imem_pc` directly. The ROM returns `imem_instr` in the same cycle.
- Next-state priority, evaluated each rising edge, highest first:
  1. `reset`:
     - PC <= `RESET_PC`.
     - `ifid_valid` <= 0.
     - `ifid_instr` <= `NOP_INSTR`.
     - `ifid_pc` <= 0 and `ifid_pc_plus2` <= 0.
     - Both counters <= 0.
  2. `redirect_valid`:
     - PC <= {`redirect_pc`[15:1], 1'b0}; misaligned targets are silently aligned.
     - Flush: `ifid_valid` <= 0 and `ifid_instr` <= `NOP_INSTR`.
     - `ifid_pc` and `ifid_pc_plus2` hold.
     - Stall is ignored in this cycle.
  3. `stall`: PC and all IF/ID fields hold.
  4. Otherwise (normal advance):
     - PC <= PC + 2.
     - `ifid_instr` <= `imem_instr`.
     - `ifid_pc` <= PC and `ifid_pc_plus2` <= PC + 2.
     - `ifid_valid` <= 1.
- PC arithmetic is modulo 2^16: 16'hFFFE + 2 = 16'h0000, with no flag.
- `ifid_pc_plus2` is also modulo 2^16.
- PC bit 0 is always 0.
- Fetching beyond the ROM range needs no special handling. The ROM returns 0 (NOP) and the fetch is counted as valid.

## Timing
- Fetch latency is one cycle: the instruction at PC is visible on `ifid_*` the cycle after PC is presented.
- Redirect penalty is one bubble:
  - Redirect asserted in cycle N loads the target PC at edge N.
  - `ifid_valid` is 0 during cycle N+1.
  - The target instruction appears on `ifid_*` in cycle N+2, provided there is no stall at edge N+1.
- Back-to-back redirects: each redirect reloads the PC and keeps `ifid_valid` low.
- Stall while `ifid_valid` is 0: the bubble is preserved.
- Reset mid-operation takes precedence over redirect and stall. All outputs take their reset values at the next edge.
- After reset deasserts, the first valid instruction appears on `ifid_*` one cycle later.

## Configuration
- Macro `FETCH_PERF_CNT_EN`.
- Defined:
  - `fetch_count` increments on every normal-advance edge.
  - `bubble_count` increments on every non-reset edge where `ifid_valid` is 0 before the edge.
  - Both counters are 16-bit and saturate at 16'hFFFF.
  - Both are cleared only by `reset`.
- Undefined: no counter logic is generated. `fetch_count` and `bubble_count` are tied to 16'h0000. Ports remain present so integration is unchanged.

## Structure
- Shared package `core_pkg` holds:
  - `addr_t` (logic [15:0]) and `instr_t` (logic [15:0]).
  - Constants `RESET_PC_DEFAULT` = 16'h0000 and `NOP_INSTR_DEFAULT` = 16'h0000.
  - `PC_STEP` = 2.
- One sub-module, `sat_counter`: a 16-bit saturating counter with inc/clear inputs, instantiated twice under `FETCH_PERF_CNT_EN`.
- The PC register, next-PC mux and IF/ID register stay in `fetch_unit`.

## Test plan
- Reset then free-run with a ROM model holding a program at 0..14:
  - `ifid_pc` sequence is 0, 2, 4, …, one cycle behind `imem_pc`.
  - `ifid_valid` rises exactly one cycle after reset deasserts.
  - `ifid_instr` matches the ROM word at each address.
- Stall held 3 cycles at PC = 6: `imem_pc` stays 6 and `ifid_pc` stays 4 for 3 cycles. The advance then resumes with `ifid_pc` = 6.
- Redirect to 16'h0003 while stall = 1:
  - PC becomes 16'h0002.
  - `ifid_valid` = 0 and `ifid_instr` = 0 for one cycle.
  - The next cycle gives `ifid_pc` = 2.
- PC at 16'hFFFE with normal advance: PC wraps to 16'h0000, `ifid_pc` = 16'hFFFE, and `ifid_pc_plus2` = 16'h0000.
- Reset asserted during a redirect cycle: PC = `RESET_PC` and `ifid_valid` = 0, with no redirect target loaded.
- With `FETCH_PERF_CNT_EN`:
  - Five advances plus one redirect gives `fetch_count` = 5 and `bubble_count` counting the redirect bubble plus the initial post-reset bubble.
  - A forced 16'hFFFF stays 16'hFFFF.
  - Without the macro, both counters read 0 throughout.
